// File: rtl/maze_pkg.sv
// Shared definitions for the maze memory arbiter: index width, FSM encoding,
// cell encoding and a small one-hot helper.
package maze_pkg;

  localparam int MAZE_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  localparam logic WALL = 1'b1;
  localparam logic PATH = 1'b0;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/maze_mem_arbiter_if.sv
// Bundle of the two requester ports and the maze memory port.
// master = solvers + memory side, slave = the arbiter.
interface maze_mem_arbiter_if #(
  parameter int maze_width = maze_pkg::MAZE_WIDTH
) ();
  logic                  req0, req1;
  logic [maze_width-1:0] row0, col0, row1, col1;
  logic                  we0, we1;
  logic                  gnt0, gnt1;
  logic                  rvalid0, rvalid1;
  logic                  rdata0, rdata1;
  logic [maze_width-1:0] row, col;
  logic                  maze_oe, maze_we, maze_in;
  logic                  busy;

  modport slave (
    input  req0, req1, row0, col0, row1, col1, we0, we1, maze_in,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           row, col, maze_oe, maze_we, busy
  );

  modport master (
    output req0, req1, row0, col0, row1, col1, we0, we1, maze_in,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           row, col, maze_oe, maze_we, busy
  );
endinterface

// File: rtl/maze_mem_arbiter_rr_arb2.sv
// Two-way round-robin picker. ptr_i names the favoured requester when both ask;
// the pointer itself lives in the parent.
module rr_arb2
  import maze_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  input  logic       enable_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (enable_i) begin
      if (&req_i) gnt_o = onehot2(ptr_i);
      else        gnt_o = req_i;
    end
  end

endmodule

// File: rtl/maze_mem_arbiter.sv
// Serialises single-cell reads/writes from two solver cores onto one
// synchronous maze memory port; one operation in flight, three cycles each.
module maze_mem_arbiter
  import maze_pkg::*;
#(
  parameter int maze_width = MAZE_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  maze_mem_arbiter_if.slave bus
);

  state_e                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic [maze_width-1:0] row_q, row_d, col_q, col_d;
  logic                  oe_q, oe_d, mwe_q, mwe_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic [1:0]            rdata_q, rdata_d;
  logic [1:0]            req, gnt;

  assign req = {bus.req1, bus.req0};

  // Grants are suppressed combinationally while reset is held.
  rr_arb2 u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .enable_i(state_q == IDLE && rst_n),
    .gnt_o   (gnt)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    we_d     = we_q;
    row_d    = row_q;
    col_d    = col_q;
    oe_d     = 1'b0;
    mwe_d    = 1'b0;
    rvalid_d = 2'b00;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (|(req & gnt)) begin
          owner_d = gnt[1];
          we_d    = gnt[1] ? bus.we1  : bus.we0;
          row_d   = gnt[1] ? bus.row1 : bus.row0;
          col_d   = gnt[1] ? bus.col1 : bus.col0;
          oe_d    = !we_d;
          mwe_d   = we_d;
          ptr_d   = !gnt[1];
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        if (!we_q) rdata_d[owner_q] = bus.maze_in;
        rvalid_d[owner_q] = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      oe_q     <= 1'b0;
      mwe_q    <= 1'b0;
      rvalid_q <= 2'b00;
      rdata_q  <= {PATH, PATH};
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      row_q    <= row_d;
      col_q    <= col_d;
      oe_q     <= oe_d;
      mwe_q    <= mwe_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.gnt0    = gnt[0];
  assign bus.gnt1    = gnt[1];
  assign bus.rvalid0 = rvalid_q[0];
  assign bus.rvalid1 = rvalid_q[1];
  assign bus.rdata0  = rdata_q[0];
  assign bus.rdata1  = rdata_q[1];
  assign bus.row     = row_q;
  assign bus.col     = col_q;
  assign bus.maze_oe = oe_q;
  assign bus.maze_we = mwe_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Directed bench for maze_mem_arbiter: a transaction-level model checked every
// cycle, plus literal expectations from the hand-worked scenarios.
module tb_maze_mem_arbiter;
  import maze_pkg::*;

  localparam int W = 6;
  localparam int N = 1 << W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  maze_mem_arbiter_if #(.maze_width(W)) bus ();
  maze_mem_arbiter #(.maze_width(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic mem  [N][N];
  logic gold [N][N];
  int   nvec = 0, nmis = 0, cyc = 0;
  bit   chk_en = 0, both_seen = 0;
  int   glog_idx[$], glog_cyc[$];

  // Model: phase = cycles since the transfer edge (0 = port free).
  int           m_phase = 0;
  bit           m_ptr = 0, m_own = 0, m_we = 0;
  logic [W-1:0] m_row = '0, m_col = '0;
  bit   [1:0]   m_rv = 0, m_rd = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit [1:0] exp_gnt();
    if (!rst_n || m_phase != 0) return 2'b00;
    if (bus.req0 && bus.req1) return m_ptr ? 2'b10 : 2'b01;
    return {bus.req1, bus.req0};
  endfunction

  // Memory: write marks a WALL, read data appears the cycle after oe.
  always @(posedge clk) begin
    if (bus.maze_we) mem[bus.row][bus.col] = WALL;
    if (bus.maze_oe) bus.maze_in <= mem[bus.row][bus.col];
  end

  always @(posedge clk) begin : model
    bit [1:0] g;
    g = exp_gnt();
    cyc++;
    if (!rst_n) begin
      m_phase = 0; m_ptr = 0; m_row = '0; m_col = '0; m_rv = 0; m_rd = 0;
    end else begin
      m_rv = 0;
      if (m_phase == 0) begin
        if (g != 0) begin
          m_own = g[1];
          m_we  = g[1] ? bus.we1  : bus.we0;
          m_row = g[1] ? bus.row1 : bus.row0;
          m_col = g[1] ? bus.col1 : bus.col0;
          m_ptr = !g[1];
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (m_we) gold[m_row][m_col] = WALL;
        m_phase = 2;
      end else begin
        if (!m_we) m_rd[m_own] = gold[m_row][m_col];
        m_rv[m_own] = 1'b1;
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt",    {bus.gnt1, bus.gnt0}, exp_gnt());
      check("addr",   {bus.row, bus.col}, {m_row, m_col});
      check("cmd",    {bus.maze_oe, bus.maze_we}, (m_phase == 1) ? {!m_we, m_we} : 2'b00);
      check("rvalid", {bus.rvalid1, bus.rvalid0}, m_rv);
      check("rdata",  {bus.rdata1, bus.rdata0}, m_rd);
      check("busy",   bus.busy, m_phase != 0);
      if (bus.gnt0 && bus.gnt1) both_seen = 1;
      if (bus.req0 && bus.gnt0) begin glog_idx.push_back(0); glog_cyc.push_back(cyc); end
      if (bus.req1 && bus.gnt1) begin glog_idx.push_back(1); glog_cyc.push_back(cyc); end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        mem[i][j]  = ((i + j) % 3 == 0) ? WALL : PATH;
        gold[i][j] = mem[i][j];
      end
    mem[5][9] = WALL; gold[5][9] = WALL;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0; bus.maze_in = 0;
    bus.row0 = '0; bus.col0 = '0; bus.row1 = '0; bus.col1 = '0;

    step(); chk_en = 1;
    step();
    @(negedge clk);
    check("rst_state", {bus.row, bus.col, bus.maze_oe, bus.maze_we, bus.rvalid0,
                        bus.rvalid1, bus.rdata0, bus.rdata1, bus.busy}, 0);
    step(); rst_n = 1;

    // Read by requester 0 of cell [5,9]
    bus.req0 = 1; bus.row0 = 6'd5; bus.col0 = 6'd9; bus.we0 = 0;
    @(negedge clk); check("rd_gnt0", bus.gnt0, 1);
    step(); bus.req0 = 0;
    @(negedge clk); check("rd_cmd", {bus.row, bus.col, bus.maze_oe, bus.maze_we}, {6'd5, 6'd9, 2'b10});
    step(); step();
    @(negedge clk); check("rd_done", {bus.rvalid0, bus.rdata0}, 2'b11);

    // Write by requester 1 to [0,63]
    step(); bus.req1 = 1; bus.row1 = 6'd0; bus.col1 = 6'd63; bus.we1 = 1;
    @(negedge clk); check("wr_gnt1", bus.gnt1, 1);
    step(); bus.req1 = 0; bus.we1 = 0;
    @(negedge clk); check("wr_cmd", {bus.row, bus.col, bus.maze_oe, bus.maze_we}, {6'd0, 6'd63, 2'b01});
    step();
    @(negedge clk); check("wr_we_once", bus.maze_we, 0);
    step();
    @(negedge clk); check("wr_done", {bus.rvalid1, bus.rdata1}, 2'b10);

    // Contention: both held for 12 cycles
    step();
    bus.row0 = 6'd1; bus.col0 = 6'd2; bus.we0 = 0;
    bus.row1 = 6'd2; bus.col1 = 6'd2; bus.we1 = 0;
    bus.req0 = 1; bus.req1 = 1;
    glog_idx.delete(); glog_cyc.delete(); both_seen = 0;
    repeat (12) step();
    bus.req0 = 0; bus.req1 = 0;
    check("cont_count", glog_idx.size(), 4);
    if (glog_idx.size() == 4) begin
      check("cont_order", {glog_idx[0][0], glog_idx[1][0], glog_idx[2][0], glog_idx[3][0]}, 4'b0101);
      for (int k = 1; k < 4; k++)
        check("cont_spacing", glog_cyc[k] - glog_cyc[k-1], 3);
    end
    check("cont_both_gnt", both_seen, 0);
    repeat (3) step();

    // Reset dropped during ISSUE
    bus.req0 = 1; bus.row0 = 6'd3; bus.col0 = 6'd4; bus.we0 = 0;
    @(negedge clk); check("rst_gnt0", bus.gnt0, 1);
    step(); bus.req0 = 0; rst_n = 0;
    @(negedge clk); check("rst_issue", {bus.maze_oe, bus.gnt0, bus.gnt1}, 3'b100);
    step(); rst_n = 1;
    @(negedge clk);
    check("rst_clear", {bus.row, bus.col, bus.maze_oe, bus.maze_we, bus.rvalid0,
                        bus.rvalid1, bus.rdata0, bus.rdata1, bus.busy}, 0);
    step(); @(negedge clk); check("rst_no_rv", bus.rvalid0, 0);
    step(); @(negedge clk); check("rst_no_rv2", bus.rvalid0, 0);
    step(); bus.req0 = 1; bus.req1 = 1;
    @(negedge clk); check("rst_ptr", {bus.gnt1, bus.gnt0}, 2'b01);
    step(); bus.req0 = 0; bus.req1 = 0;
    repeat (3) step();

    // Withdrawn req1 while requester 0 writes [7,9]
    bus.req0 = 1; bus.row0 = 6'd7; bus.col0 = 6'd9; bus.we0 = 1;
    @(negedge clk); check("wd_gnt0", bus.gnt0, 1);
    step(); bus.req0 = 0; bus.we0 = 0;
    bus.req1 = 1; bus.row1 = 6'd10; bus.col1 = 6'd11; bus.we1 = 0;
    @(negedge clk);
    check("wd_gnt1", bus.gnt1, 0);
    check("wd_cmd", {bus.row, bus.col, bus.maze_oe, bus.maze_we}, {6'd7, 6'd9, 2'b01});
    step(); bus.req1 = 0;
    @(negedge clk); check("wd_busy_cap", {bus.busy, bus.maze_oe, bus.maze_we}, 3'b100);
    step();
    @(negedge clk); check("wd_end", {bus.busy, bus.rvalid0, bus.rvalid1}, 3'b010);
    repeat (2) step();

    // Read back the cell just marked
    bus.req1 = 1; bus.row1 = 6'd7; bus.col1 = 6'd9; bus.we1 = 0;
    step(); bus.req1 = 0;
    step(); step();
    @(negedge clk); check("rb_wall", {bus.rvalid1, bus.rdata1}, 2'b11);
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/maze_mem_arbiter.md
# maze_mem_arbiter

Two-requester round-robin arbiter sharing the single synchronous maze memory port (row/col select, output enable, write enable, one-bit read data) between two maze solver cores. Sits between the solvers and the maze memory, serialises their single-cell reads and writes, and returns read data and completion to the owning requester. One operation is in flight at a time; the memory sees at most one command per cycle.

## Interface
- `maze_width`, default 6: width of row and column indices.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `req0`, `req1` input 1 each: requester has an operation pending; held until granted.
- `row0`, `col0`, `row1`, `col1` input `maze_width` each: cell address; stable while `req` is high.
- `we0`, `we1` input 1 each: 1 = write (mark cell), 0 = read.
- `gnt0`, `gnt1` output 1 each: combinational grant; transfer occurs on an edge where `req && gnt`.
- `rvalid0`, `rvalid1` output 1 each: one-cycle completion pulse, for both reads and writes.
- `rdata0`, `rdata1` output 1 each: last read value for that requester; unchanged by writes.
- `row`, `col` output `maze_width` each: memory address, registered.
- `maze_oe` output 1: memory read enable, registered.
- `maze_we` output 1: memory write enable, registered.
- `maze_in` input 1: memory read data, valid the cycle after `maze_oe`.
- `busy` output 1: high in ISSUE and CAPTURE.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE: round-robin picker drives at most one `gnt`. On an edge with `req_i && gnt_i`, latch `row_i`/`col_i`/`we_i` and owner `i`, then go to ISSUE. With no request, stay in IDLE.
- ISSUE: `row`/`col` = latched address; `maze_oe = !we`, `maze_we = we`. Next state is CAPTURE.
- CAPTURE: `maze_oe`/`maze_we` = 0; `row`/`col` hold. For a read, sample `maze_in` into `rdata_owner` at the closing edge. Pulse `rvalid_owner` in the following cycle. Next state is IDLE.
- Round-robin pointer:
  - Reset value favours requester 0.
  - After each grant, the pointer favours the other requester.
  - A lone requester is granted whenever the FSM is in IDLE.
  - Simultaneous requests alternate strictly: 0, 1, 0, 1, ...
- `gnt0`/`gnt1` are 0 outside IDLE, while `rst_n` is low, and for a requester whose `req` is low. They are never both 1.
- Address arithmetic is not performed: addresses pass through unmodified at full `maze_width`.

## Timing
- Reset values:
  - `row` = 0, `col` = 0.
  - `maze_oe` = 0, `maze_we` = 0.
  - `rvalid0/1` = 0, `rdata0/1` = 0.
  - `busy` = 0.
  - FSM = IDLE, pointer = 0.
- Operation latency, with the transfer edge as E0:
  - Cycle 1: ISSUE, command on the memory port.
  - Cycle 2: CAPTURE, `maze_in` valid.
  - Cycle 3: `rvalid` high; FSM is back in IDLE and may grant again in that same cycle.
- Throughput: one operation per 3 cycles; back-to-back operations cause no bubble beyond this.
- Reset mid-operation:
  - Outputs return to reset values at the next edge.
  - The in-flight operation is dropped; no `rvalid` is produced for it.
  - The pointer returns to 0.
- A `req` deasserted before it is granted is legal; nothing is issued for it.
- A `req` held through its own `rvalid` is treated as a new request.

## Structure
- Shared package `maze_pkg`:
  - `MAZE_WIDTH` default (6).
  - FSM state encoding (IDLE, ISSUE, CAPTURE).
  - Cell encoding constants: `WALL` = 1, `PATH` = 0.
- Sub-module `rr_arb2`:
  - Two-way round-robin picker.
  - Inputs: `req[1:0]`, `ptr`, `enable`. Output: one-hot `gnt`.
  - Pointer update is done in the parent on the transfer edge.

## Test plan
- Read by requester 0 only: `req0` = 1, `row0` = 5, `col0` = 9, `we0` = 0; memory cell [5,9] = 1.
  - Expect `gnt0` in cycle 0.
  - Expect `row` = 5, `col` = 9, `maze_oe` = 1 in cycle 1.
  - Expect `rvalid0` = 1 and `rdata0` = 1 in cycle 3.
- Write by requester 1: `row1` = 0, `col1` = 63, `we1` = 1.
  - Expect `maze_we` = 1 for exactly one cycle (cycle 1), with `maze_oe` = 0.
  - Expect `rvalid1` pulse in cycle 3, with `rdata1` unchanged.
- Contention: both `req` held high for 12 cycles.
  - Expect grants in order 0, 1, 0, 1, spaced exactly 3 cycles apart.
  - Expect `gnt0 && gnt1` never true.
- Reset mid-operation: drop `rst_n` in the ISSUE cycle for one cycle.
  - Expect all outputs 0 the next cycle and no `rvalid`.
  - After release, the next grant goes to requester 0.
- Withdrawn request: `req1` pulses for one cycle while requester 0 owns the port.
  - Expect no grant to requester 1 and no memory command for it.
  - Expect `busy` to fall after requester 0's CAPTURE.
